pipe_hazard_ctrl: RTL

Central stall/flush controller for the 5-stage pipeline. Generates the enable and clear strobes for the PC and the FD/DE/EM/MW pipeline registers. Inputs are register-use times (Tuse/Tnew), a multi-cycle mult/div busy counter and the exception request Req. Sits beside the datapath; all pipeline registers take their en/clear from this block only.

---
 rtl/pipe_hazard_ctrl.sv | 110 +++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: RAW hazards from Tuse/Tnew,
// HI/LO busy tracking and exception flush, plus a saturating stall counter.
module pipe_hazard_ctrl #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_rs_addr,
  input  logic [4:0]  D_rt_addr,
  input  logic [1:0]  D_rs_tuse,
  input  logic [1:0]  D_rt_tuse,
  input  logic        D_is_md,
  input  logic [4:0]  E_write_addr,
  input  logic [1:0]  E_tnew,
  input  logic [4:0]  M_write_addr,
  input  logic [1:0]  M_tnew,
  input  logic        E_md_start,
  input  logic        E_md_type,
  input  logic        Req,
  output logic        PC_en,
  output logic        FD_en,
  output logic        FD_clear,
  output logic        DE_clear,
  output logic        EM_clear,
  output logic        MW_en,
  output logic        MW_clear,
  output logic        md_busy,
  output logic [31:0] stall_cnt
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYC);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYC);

  logic [3:0]  md_cnt_q, md_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [4:0]  src_addr [2];
  logic [1:0]  src_tuse [2];
  logic [1:0]  src_hit;
  logic        start_eff;
  logic        stall_md;
  logic        stall;

  assign src_addr[0] = D_rs_addr;
  assign src_addr[1] = D_rt_addr;
  assign src_tuse[0] = D_rs_tuse;
  assign src_tuse[1] = D_rt_tuse;

  // Register $0 is never a real dependency; tuse=3 can never lose to tnew<=2.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      assign src_hit[gi] = (src_addr[gi] != 5'd0) &
                           (((src_addr[gi] == E_write_addr) & (E_tnew > src_tuse[gi])) |
                            ((src_addr[gi] == M_write_addr) & (M_tnew > src_tuse[gi])));
    end
  endgenerate

  // A start in the exception cycle belongs to the victim and is discarded.
  assign start_eff = E_md_start & ~Req;
  assign md_busy   = (md_cnt_q != 4'd0) | start_eff;
  assign stall_md  = D_is_md & md_busy;
  assign stall     = ((|src_hit) | stall_md) & ~Req;
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    PC_en    = 1'b1;
    FD_en    = 1'b1;
    FD_clear = 1'b0;
    DE_clear = 1'b0;
    EM_clear = 1'b0;
    MW_en    = 1'b1;
    MW_clear = 1'b0;
    if (Req) begin
      FD_clear = 1'b1;
      DE_clear = 1'b1;
      EM_clear = 1'b1;
      MW_clear = 1'b1;
    end else if (stall) begin
      PC_en    = 1'b0;
      FD_en    = 1'b0;
      DE_clear = 1'b1;
    end
  end

  always_comb begin
    md_cnt_d    = md_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (!Req) begin
      if (E_md_start) begin
        md_cnt_d = E_md_type ? DIV_LOAD : MULT_LOAD;
      end else if (md_cnt_q != 4'd0) begin
        md_cnt_d = md_cnt_q - 4'd1;
      end
    end
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      md_cnt_q    <= 4'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
